spu_regfile_forward: RTL and testbench

// - Register-file/forwarding stage feeding the SPU fixed-point execute pipe; consumes that pipe's write-back and forward outputs.
// - 128 x 128-bit register file, 1 write port (WB), 3 read ports (ra, rb, rc/store) with operand forwarding.
// - Registers the decoded instruction plus the resolved operands toward execute: 1-cycle latency, stall and flush support.

---
 rtl/spu_pkg.sv | 34 +++
 rtl/spu_operand_mux.sv | 39 +++
 rtl/spu_regfile_forward.sv | 137 +++++++++++++
 tb/tb_spu_regfile_forward.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// ============================================================================
// Module : spu_pkg
// Shared widths, types and instruction-format codes for the SPU issue path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package spu_pkg;

  localparam int REG_W    = 128;
  localparam int ADDR_W   = 7;
  localparam int OPCODE_W = 11;
  localparam int IMM_W    = 18;
  localparam int NUM_REGS = 128;

  localparam logic [OPCODE_W-1:0] OP_NOP = '0;

  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [ADDR_W-1:0] raddr_t;

  typedef enum logic [2:0] {
    FMT_RR    = 3'd0,
    FMT_RRR   = 3'd1,
    FMT_RI7   = 3'd2,
    FMT_RI8   = 3'd3,
    FMT_RI10  = 3'd4,
    FMT_RI16  = 3'd5,
    FMT_RI18  = 3'd6,
    FMT_OTHER = 3'd7
  } instr_format_e;

endpackage

`default_nettype wire

// File: rtl/spu_operand_mux.sv
// ============================================================================
// Module : spu_operand_mux
// Priority select for one source operand: forward stages, WB bypass, array.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spu_operand_mux
  import spu_pkg::*;
#(
  parameter int FWD_STAGES = 3
) (
  input  raddr_t                        addr,
  input  logic [FWD_STAGES*REG_W-1:0]   fwd_data,
  input  logic [FWD_STAGES*ADDR_W-1:0]  fwd_addr,
  input  logic [FWD_STAGES-1:0]         fwd_en,
  input  reg_t                          wb_data,
  input  raddr_t                        wb_addr,
  input  logic                          wb_en,
  input  reg_t                          arr_data,
  output reg_t                          data
);

  // Walk oldest-to-youngest so the lowest matching stage index wins last.
  always_comb begin
    data = arr_data;
    if (wb_en && (wb_addr == addr)) begin
      data = wb_data;
    end
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (fwd_en[i] && (fwd_addr[i*ADDR_W +: ADDR_W] == addr)) begin
        data = fwd_data[i*REG_W +: REG_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spu_regfile_forward.sv
// ============================================================================
// Module : spu_regfile_forward
// 128x128 register file with forwarding; registers instruction + operands.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spu_regfile_forward
  import spu_pkg::*;
#(
  parameter int FWD_STAGES = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [OPCODE_W-1:0]           issue_op_code,
  input  logic [2:0]                    issue_instr_format,
  input  raddr_t                        issue_ra_addr,
  input  raddr_t                        issue_rb_addr,
  input  raddr_t                        issue_rc_addr,
  input  raddr_t                        issue_dest_addr,
  input  logic [IMM_W-1:0]              issue_imm,
  input  logic                          issue_reg_write,
  input  logic                          stall,
  input  logic                          branch_is_taken,
  input  logic [FWD_STAGES*REG_W-1:0]   fwd_data,
  input  logic [FWD_STAGES*ADDR_W-1:0]  fwd_addr,
  input  logic [FWD_STAGES-1:0]         fwd_en,
  input  reg_t                          wb_data,
  input  raddr_t                        wb_reg_addr,
  input  logic                          wb_enable_reg_write,
  output logic [OPCODE_W-1:0]           op_code,
  output instr_format_e                 instr_format,
  output raddr_t                        dest_reg_addr,
  output logic [IMM_W-1:0]              imm_value,
  output logic                          enable_reg_write,
  output reg_t                          src_reg_a,
  output reg_t                          src_reg_b,
  output reg_t                          store_reg
);

  reg_t   r_regs [NUM_REGS];
  raddr_t r_held_ra;
  raddr_t r_held_rb;
  raddr_t r_held_rc;
  logic   r_held_valid;

  raddr_t w_rd_addr [3];
  reg_t   w_rd_data [3];

  // A stalled instruction keeps reading its own sources so late write-backs land.
  always_comb begin
    w_rd_addr[0] = issue_ra_addr;
    w_rd_addr[1] = issue_rb_addr;
    w_rd_addr[2] = issue_rc_addr;
    if (stall) begin
      w_rd_addr[0] = r_held_ra;
      w_rd_addr[1] = r_held_rb;
      w_rd_addr[2] = r_held_rc;
    end
  end

  generate
    for (genvar g = 0; g < 3; g++) begin : g_read_port
      spu_operand_mux #(
        .FWD_STAGES (FWD_STAGES)
      ) u_mux (
        .addr     (w_rd_addr[g]),
        .fwd_data (fwd_data),
        .fwd_addr (fwd_addr),
        .fwd_en   (fwd_en),
        .wb_data  (wb_data),
        .wb_addr  (wb_reg_addr),
        .wb_en    (wb_enable_reg_write),
        .arr_data (r_regs[w_rd_addr[g]]),
        .data     (w_rd_data[g])
      );
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_enable_reg_write) begin
      r_regs[wb_reg_addr] <= wb_data;
    end
  end

  // A held nop (after reset or flush) keeps its operands at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_code          <= OP_NOP;
      instr_format     <= FMT_RR;
      dest_reg_addr    <= '0;
      imm_value        <= '0;
      enable_reg_write <= 1'b0;
      src_reg_a        <= '0;
      src_reg_b        <= '0;
      store_reg        <= '0;
      r_held_ra        <= '0;
      r_held_rb        <= '0;
      r_held_rc        <= '0;
      r_held_valid     <= 1'b0;
    end else if (branch_is_taken) begin
      op_code          <= OP_NOP;
      instr_format     <= FMT_RR;
      dest_reg_addr    <= '0;
      imm_value        <= '0;
      enable_reg_write <= 1'b0;
      src_reg_a        <= '0;
      src_reg_b        <= '0;
      store_reg        <= '0;
      r_held_valid     <= 1'b0;
    end else if (stall) begin
      src_reg_a        <= r_held_valid ? w_rd_data[0] : '0;
      src_reg_b        <= r_held_valid ? w_rd_data[1] : '0;
      store_reg        <= r_held_valid ? w_rd_data[2] : '0;
    end else begin
      op_code          <= issue_op_code;
      instr_format     <= instr_format_e'(issue_instr_format);
      dest_reg_addr    <= issue_dest_addr;
      imm_value        <= issue_imm;
      enable_reg_write <= issue_reg_write;
      src_reg_a        <= w_rd_data[0];
      src_reg_b        <= w_rd_data[1];
      store_reg        <= w_rd_data[2];
      r_held_ra        <= issue_ra_addr;
      r_held_rb        <= issue_rb_addr;
      r_held_rc        <= issue_rc_addr;
      r_held_valid     <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spu_regfile_forward.sv
// ============================================================================
// Module : tb_spu_regfile_forward
// Scoreboard bench: directed cases plus random traffic against a reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_spu_regfile_forward;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [10:0]   issue_op_code;
  logic [2:0]    issue_instr_format;
  logic [6:0]    issue_ra_addr, issue_rb_addr, issue_rc_addr, issue_dest_addr;
  logic [17:0]   issue_imm;
  logic          issue_reg_write;
  logic          stall, branch_is_taken;
  logic [383:0]  fwd_data;
  logic [20:0]   fwd_addr;
  logic [2:0]    fwd_en;
  logic [127:0]  wb_data;
  logic [6:0]    wb_reg_addr;
  logic          wb_enable_reg_write;
  logic [10:0]   op_code;
  logic [2:0]    instr_format;
  logic [6:0]    dest_reg_addr;
  logic [17:0]   imm_value;
  logic          enable_reg_write;
  logic [127:0]  src_reg_a, src_reg_b, store_reg;

  spu_regfile_forward #(.FWD_STAGES(3)) dut (
    .clock(clock), .reset(reset),
    .issue_op_code(issue_op_code), .issue_instr_format(issue_instr_format),
    .issue_ra_addr(issue_ra_addr), .issue_rb_addr(issue_rb_addr),
    .issue_rc_addr(issue_rc_addr), .issue_dest_addr(issue_dest_addr),
    .issue_imm(issue_imm), .issue_reg_write(issue_reg_write),
    .stall(stall), .branch_is_taken(branch_is_taken),
    .fwd_data(fwd_data), .fwd_addr(fwd_addr), .fwd_en(fwd_en),
    .wb_data(wb_data), .wb_reg_addr(wb_reg_addr),
    .wb_enable_reg_write(wb_enable_reg_write),
    .op_code(op_code), .instr_format(instr_format),
    .dest_reg_addr(dest_reg_addr), .imm_value(imm_value),
    .enable_reg_write(enable_reg_write),
    .src_reg_a(src_reg_a), .src_reg_b(src_reg_b), .store_reg(store_reg)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           cyc;
    logic [10:0]  op;
    logic [2:0]   fmt;
    logic [6:0]   dest;
    logic [17:0]  imm;
    logic         we;
    logic [127:0] a, b, c;
  } exp_t;

  exp_t         q[$];
  exp_t         m_out;
  logic [127:0] m_mem [128];
  logic [6:0]   h_ra, h_rb, h_rc;
  logic         h_valid;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] resolve(input logic [6:0] s);
    for (int i = 0; i < 3; i++)
      if (fwd_en[i] && fwd_addr[i*7 +: 7] == s) return fwd_data[i*128 +: 128];
    if (wb_enable_reg_write && wb_reg_addr == s) return wb_data;
    return m_mem[s];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_mem[i] = '0;
    m_out = '{default: '0};
    h_ra = '0; h_rb = '0; h_rc = '0;
    h_valid = 1'b0;
  endtask

  task automatic clr_in();
    issue_op_code = '0; issue_instr_format = '0;
    issue_ra_addr = '0; issue_rb_addr = '0; issue_rc_addr = '0; issue_dest_addr = '0;
    issue_imm = '0; issue_reg_write = 1'b0;
    stall = 1'b0; branch_is_taken = 1'b0;
    fwd_data = '0; fwd_addr = '0; fwd_en = '0;
    wb_data = '0; wb_reg_addr = '0; wb_enable_reg_write = 1'b0;
  endtask

  // Predict the outputs after the coming edge from the current inputs, then advance.
  task automatic tick();
    exp_t e;
    if (branch_is_taken) begin
      e = '{default: '0};
      h_valid = 1'b0;
    end else if (stall) begin
      e = m_out;
      e.a = h_valid ? resolve(h_ra) : '0;
      e.b = h_valid ? resolve(h_rb) : '0;
      e.c = h_valid ? resolve(h_rc) : '0;
    end else begin
      e.op = issue_op_code; e.fmt = issue_instr_format; e.dest = issue_dest_addr;
      e.imm = issue_imm; e.we = issue_reg_write;
      e.a = resolve(issue_ra_addr); e.b = resolve(issue_rb_addr); e.c = resolve(issue_rc_addr);
      h_ra = issue_ra_addr; h_rb = issue_rb_addr; h_rc = issue_rc_addr;
      h_valid = 1'b1;
    end
    e.cyc = cyc + 1;
    q.push_back(e);
    m_out = e;
    if (wb_enable_reg_write) m_mem[wb_reg_addr] = wb_data;
    @(negedge clock); #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_op"}, 128'(op_code), 128'd0);
    chk({tag, "_fmt"}, 128'(instr_format), 128'd0);
    chk({tag, "_dest"}, 128'(dest_reg_addr), 128'd0);
    chk({tag, "_imm"}, 128'(imm_value), 128'd0);
    chk({tag, "_we"}, 128'(enable_reg_write), 128'd0);
    chk({tag, "_a"}, src_reg_a, 128'd0);
    chk({tag, "_b"}, src_reg_b, 128'd0);
    chk({tag, "_c"}, store_reg, 128'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock); #2;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        chk("op_code", 128'(op_code), 128'(e.op));
        chk("instr_format", 128'(instr_format), 128'(e.fmt));
        chk("dest_reg_addr", 128'(dest_reg_addr), 128'(e.dest));
        chk("imm_value", 128'(imm_value), 128'(e.imm));
        chk("enable_reg_write", 128'(enable_reg_write), 128'(e.we));
        chk("src_reg_a", src_reg_a, e.a);
        chk("src_reg_b", src_reg_b, e.b);
        chk("store_reg", store_reg, e.c);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    clr_in();
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clock); #1;
    reset = 1'b1;

    // Write r3 via WB, then read it back.
    clr_in(); wb_enable_reg_write = 1'b1; wb_reg_addr = 7'd3;
    wb_data = 128'h1A2B3C4D5E6F708192A3B4C5D6E7F8C6; tick();
    clr_in(); issue_op_code = 11'h041; issue_ra_addr = 7'd3; tick();

    // Same-cycle WB bypass.
    clr_in(); wb_enable_reg_write = 1'b1; wb_reg_addr = 7'd5;
    wb_data = {32{4'hA}}; issue_ra_addr = 7'd5; issue_op_code = 11'h042; tick();

    // Two forward stages hit the same address: stage 0 wins.
    clr_in(); fwd_en = 3'b011; fwd_addr[6:0] = 7'd7; fwd_addr[13:7] = 7'd7;
    fwd_data[127:0] = 128'h1; fwd_data[255:128] = 128'h2; issue_rb_addr = 7'd7; tick();

    // ahi held by a 3-cycle stall while r3 is rewritten.
    clr_in(); issue_op_code = 11'b00000011101; issue_instr_format = 3'd4;
    issue_ra_addr = 7'd3; issue_dest_addr = 7'd9; issue_imm = 18'h3F; issue_reg_write = 1'b1; tick();
    clr_in(); stall = 1'b1; issue_op_code = 11'h7FF; issue_ra_addr = 7'd1; tick();
    wb_enable_reg_write = 1'b1; wb_reg_addr = 7'd3; wb_data = {32{4'h5}}; tick();
    clr_in(); stall = 1'b1; tick();

    // Flush overrides stall.
    clr_in(); stall = 1'b1; branch_is_taken = 1'b1; issue_op_code = 11'h123; issue_reg_write = 1'b1; tick();
    clr_in(); stall = 1'b1; tick();

    // Random traffic over a small address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      issue_op_code      = 11'($urandom);
      issue_instr_format = 3'($urandom);
      issue_ra_addr      = 7'($urandom_range(0, 7));
      issue_rb_addr      = 7'($urandom_range(0, 7));
      issue_rc_addr      = 7'($urandom_range(0, 7));
      issue_dest_addr    = 7'($urandom);
      issue_imm          = 18'($urandom);
      issue_reg_write    = 1'($urandom);
      stall              = ($urandom_range(0, 3) == 0);
      branch_is_taken    = ($urandom_range(0, 9) == 0);
      fwd_en             = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        fwd_addr[i*7 +: 7]     = 7'($urandom_range(0, 7));
        fwd_data[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
      end
      wb_enable_reg_write = 1'($urandom);
      wb_reg_addr         = 7'($urandom_range(0, 7));
      wb_data             = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end

    // Reset mid-stream while an instruction sits on the outputs.
    clr_in(); wb_enable_reg_write = 1'b1; wb_reg_addr = 7'd3; wb_data = {32{4'hC}}; tick();
    clr_in(); issue_op_code = 11'b00011000000; issue_ra_addr = 7'd3; issue_reg_write = 1'b1; tick();
    stall = 1'b1; reset = 1'b0; #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clock); #1;
    clr_in(); reset = 1'b1;
    issue_op_code = 11'h055; issue_ra_addr = 7'd3; issue_rc_addr = 7'd3; tick();
    clr_in(); tick();

    repeat (3) @(negedge clock);
    chk("queue_drain", 128'(q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
